bit_trigger_control: RTL and testbench

BIT_TRIGGER_CONTROL -- requirements
Module: bit_trigger_control

---
 rtl/bit_plotter_pkg.sv | 13 +
 rtl/bit_trigger_control_if.sv | 24 ++
 rtl/bit_input_conditioner.sv | 41 ++++
 rtl/bit_trigger_control.sv | 120 ++++++++++++
 tb/tb_bit_trigger_control.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/bit_plotter_pkg.sv
// Shared constants and state encoding for the bit plotter and its trigger control.
package bit_plotter_pkg;

  localparam int unsigned PLOT_SAMPLES = 16384;
  localparam int unsigned PLOT_INDEX_W = $clog2(PLOT_SAMPLES);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_CLEAR   = 3'd1;
  localparam logic [2:0] ST_ARMED   = 3'd2;
  localparam logic [2:0] ST_RUNNING = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

endpackage

// File: rtl/bit_trigger_control_if.sv
// Probe inputs and plotter-control outputs of the trigger controller.
interface bit_trigger_control_if;

  logic rawIn;
  logic armIn;
  logic triggerRising;
  logic bitOut;
  logic clear;
  logic start;
  logic sampleStrobe;
  logic armed;
  logic running;

  modport master (
    output rawIn, armIn, triggerRising,
    input  bitOut, clear, start, sampleStrobe, armed, running
  );

  modport slave (
    input  rawIn, armIn, triggerRising,
    output bitOut, clear, start, sampleStrobe, armed, running
  );

endinterface

// File: rtl/bit_input_conditioner.sv
// Multi-flop synchronizer followed by a consecutive-sample glitch filter.
module bit_input_conditioner #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  localparam int unsigned CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   dout_q;
  logic                   sync_bit;

  assign sync_bit = sync_q[SYNC_STAGES-1];
  assign dout     = dout_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      cnt_q  <= '0;
      dout_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      // cnt_q counts how many consecutive samples have disagreed with dout_q
      if (sync_bit == dout_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
        dout_q <= sync_bit;
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/bit_trigger_control.sv
// Arms on a button edge, clears the plot, waits for a filtered probe edge, then
// paces SAMPLE_COUNT sample strobes PRESCALE cycles apart.
module bit_trigger_control
  import bit_plotter_pkg::*;
#(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned FILTER_LEN   = 4,
  parameter int unsigned PRESCALE     = 32768,
  parameter int unsigned SAMPLE_COUNT = PLOT_SAMPLES
) (
  input logic                  clk,
  input logic                  reset,
  bit_trigger_control_if.slave bus
);

  localparam int unsigned PRE_W  = $clog2(PRESCALE);
  localparam int unsigned SCNT_W = $clog2(SAMPLE_COUNT + 1);

  logic              bit_f, arm_f;
  logic              bit_prev_q, arm_prev_q;
  logic              arm_evt, qual_edge;
  logic [2:0]        state_q, state_d;
  logic [PRE_W-1:0]  presc_q, presc_d;
  logic [SCNT_W-1:0] scnt_q, scnt_d;
  logic              start_d, strobe_d;
  logic              clear_q, start_q, strobe_q, armed_q, running_q;

  bit_input_conditioner #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILTER_LEN  (FILTER_LEN)
  ) u_raw (
    .clk   (clk),
    .reset (reset),
    .din   (bus.rawIn),
    .dout  (bit_f)
  );

  bit_input_conditioner #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILTER_LEN  (1)
  ) u_arm (
    .clk   (clk),
    .reset (reset),
    .din   (bus.armIn),
    .dout  (arm_f)
  );

  assign arm_evt   = arm_f & ~arm_prev_q;
  assign qual_edge = bus.triggerRising ? (bit_f & ~bit_prev_q) : (~bit_f & bit_prev_q);

  // start is registered on entry to RUNNING; the first strobe follows one cycle
  // later so the three pulses never coincide.
  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    scnt_d   = scnt_q;
    start_d  = 1'b0;
    strobe_d = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (arm_evt) state_d = ST_CLEAR;
      end
      ST_CLEAR: state_d = ST_ARMED;
      ST_ARMED: begin
        if (qual_edge) begin
          state_d = ST_RUNNING;
          start_d = 1'b1;
          presc_d = '0;
          scnt_d  = '0;
        end
      end
      ST_RUNNING: begin
        if (scnt_q == SCNT_W'(SAMPLE_COUNT)) begin
          state_d = ST_DONE;
        end else begin
          presc_d = (presc_q == PRE_W'(PRESCALE - 1)) ? '0 : presc_q + 1'b1;
          if (presc_q == '0) begin
            strobe_d = 1'b1;
            scnt_d   = scnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      presc_q    <= '0;
      scnt_q     <= '0;
      bit_prev_q <= 1'b0;
      arm_prev_q <= 1'b0;
      clear_q    <= 1'b0;
      start_q    <= 1'b0;
      strobe_q   <= 1'b0;
      armed_q    <= 1'b0;
      running_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      scnt_q     <= scnt_d;
      bit_prev_q <= bit_f;
      arm_prev_q <= arm_f;
      clear_q    <= (state_d == ST_CLEAR);
      start_q    <= start_d;
      strobe_q   <= strobe_d;
      armed_q    <= (state_d == ST_ARMED);
      running_q  <= (state_d == ST_RUNNING);
    end
  end

  assign bus.bitOut       = bit_f;
  assign bus.clear        = clear_q;
  assign bus.start        = start_q;
  assign bus.sampleStrobe = strobe_q;
  assign bus.armed        = armed_q;
  assign bus.running      = running_q;

endmodule

// File: tb/tb_bit_trigger_control.sv
// Directed bench for bit_trigger_control with SYNC_STAGES=2, FILTER_LEN=3, PRESCALE=4,
// SAMPLE_COUNT=8.
module tb_bit_trigger_control;
  import bit_plotter_pkg::*;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  bit_trigger_control_if bus ();

  bit_trigger_control #(
    .SYNC_STAGES  (2),
    .FILTER_LEN   (3),
    .PRESCALE     (4),
    .SAMPLE_COUNT (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int clear_cnt = 0;
  int start_cnt = 0;
  int strobe_cnt = 0;
  int spacing_err = 0;
  int first_gap = -1;
  int start_cyc = 0;
  int last_strobe = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_counts();
    clear_cnt   = 0;
    start_cnt   = 0;
    strobe_cnt  = 0;
    spacing_err = 0;
    first_gap   = -1;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse counting and spacing, sampled mid-cycle
  always @(negedge clk) begin
    check("pulse_exclusive",
          32'($countones({bus.clear, bus.start, bus.sampleStrobe}) <= 1), 32'd1);
    if (bus.clear) clear_cnt++;
    if (bus.start) begin
      start_cnt++;
      start_cyc = cyc;
    end
    if (bus.sampleStrobe) begin
      if (strobe_cnt == 0) first_gap = cyc - start_cyc;
      else if (cyc - last_strobe != 4) spacing_err++;
      last_strobe = cyc;
      strobe_cnt++;
    end
  end

  int n;
  logic seen;

  initial begin
    reset = 1'b1;
    bus.rawIn = 1'b0;
    bus.armIn = 1'b0;
    bus.triggerRising = 1'b1;
    repeat (3) tick();
    check("reset_outputs", {26'd0, bus.bitOut, bus.clear, bus.start, bus.sampleStrobe,
                            bus.armed, bus.running}, 32'd0);
    check("reset_state", dut.state_q, ST_IDLE);
    reset = 1'b0;

    // Filter latency and glitch rejection
    bus.rawIn = 1'b1;
    repeat (4) tick();
    check("bit_before_latency", bus.bitOut, 0);
    tick();
    check("bit_after_latency", bus.bitOut, 1);
    bus.rawIn = 1'b0;
    repeat (6) tick();
    check("bit_fall", bus.bitOut, 0);
    bus.rawIn = 1'b1;
    tick();
    tick();
    bus.rawIn = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      seen = seen | bus.bitOut;
    end
    check("glitch_rejected", seen, 0);
    check("no_clear_without_arm", clear_cnt, 0);

    // Full rising-edge capture
    clr_counts();
    bus.armIn = 1'b1;
    n = 0;
    while (!bus.armed && n < 20) begin tick(); n++; end
    check("arm_reached", bus.armed, 1);
    check("arm_clear_once", clear_cnt, 1);
    check("arm_no_start", start_cnt, 0);
    bus.armIn = 1'b0;
    bus.rawIn = 1'b1;
    n = 0;
    while (start_cnt == 0 && n < 20) begin tick(); n++; end
    check("rise_start", start_cnt, 1);
    check("rise_running", bus.running, 1);
    check("rise_armed_low", bus.armed, 0);
    n = 0;
    while (bus.running && n < 100) begin tick(); n++; end
    check("capture_ended", bus.running, 0);
    check("strobe_count", strobe_cnt, 8);
    check("first_strobe_gap", first_gap, 1);
    check("strobe_spacing", spacing_err, 0);
    check("done_state", dut.state_q, ST_DONE);
    repeat (10) tick();
    check("no_strobe_after_done", strobe_cnt, 8);
    check("single_start", start_cnt, 1);

    // Falling-edge trigger: rising edge alone must not start
    bus.rawIn = 1'b0;
    repeat (8) tick();
    bus.triggerRising = 1'b0;
    clr_counts();
    bus.armIn = 1'b1;
    n = 0;
    while (!bus.armed && n < 20) begin tick(); n++; end
    check("rearm_from_done", bus.armed, 1);
    bus.armIn = 1'b0;
    bus.rawIn = 1'b1;
    repeat (10) tick();
    check("fall_mode_rise_ignored", start_cnt, 0);
    check("fall_mode_still_armed", bus.armed, 1);
    bus.rawIn = 1'b0;
    n = 0;
    while (start_cnt == 0 && n < 20) begin tick(); n++; end
    check("fall_start", start_cnt, 1);
    check("fall_running", bus.running, 1);

    // Reset mid-capture after the 3rd strobe
    n = 0;
    while (strobe_cnt < 3 && n < 100) begin tick(); n++; end
    check("third_strobe_reached", strobe_cnt, 3);
    reset = 1'b1;
    tick();
    check("abort_outputs", {26'd0, bus.bitOut, bus.clear, bus.start, bus.sampleStrobe,
                            bus.armed, bus.running}, 32'd0);
    check("abort_state", dut.state_q, ST_IDLE);
    repeat (2) tick();
    reset = 1'b0;
    repeat (20) tick();
    check("abort_no_more_strobes", strobe_cnt, 3);
    check("abort_no_clear", clear_cnt, 1);
    clr_counts();
    bus.armIn = 1'b1;
    n = 0;
    while (!bus.armed && n < 20) begin tick(); n++; end
    bus.armIn = 1'b0;
    repeat (10) tick();
    check("post_reset_clear_once", clear_cnt, 1);

    // Arm and qualified edge coinciding in IDLE
    reset = 1'b1;
    bus.triggerRising = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    clr_counts();
    bus.rawIn = 1'b1;
    tick();
    tick();
    bus.armIn = 1'b1;
    n = 0;
    while (!bus.armed && n < 20) begin tick(); n++; end
    repeat (10) tick();
    check("coincident_no_start", start_cnt, 0);
    check("coincident_clear", clear_cnt, 1);
    check("coincident_armed", bus.armed, 1);
    bus.armIn = 1'b0;
    bus.rawIn = 1'b0;
    repeat (8) tick();
    check("falling_ignored_rise_mode", bus.armed, 1);
    bus.rawIn = 1'b1;
    n = 0;
    while (start_cnt == 0 && n < 20) begin tick(); n++; end
    check("rearm_run_start", start_cnt, 1);
    repeat (2) tick();
    bus.armIn = 1'b1;
    repeat (4) tick();
    bus.armIn = 1'b0;
    repeat (4) tick();
    bus.armIn = 1'b1;
    repeat (4) tick();
    bus.armIn = 1'b0;
    n = 0;
    while (bus.running && n < 100) begin tick(); n++; end
    check("arm_in_run_strobes", strobe_cnt, 8);
    check("arm_in_run_no_clear", clear_cnt, 1);
    check("arm_in_run_done", dut.state_q, ST_DONE);
    bus.armIn = 1'b1;
    n = 0;
    while (!bus.armed && n < 20) begin tick(); n++; end
    check("done_rearm_clear", clear_cnt, 2);
    bus.armIn = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
